// File: rtl/sync_fifo_core.sv
// Synchronous FIFO with registered RAM read stage and separately enabled output register.
// Optional registered almost_full flag is built when FIFO_ALMOST_FULL_EN is defined.
module sync_fifo_core #(
    parameter int unsigned W      = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned AF_LVL = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    input  logic         reg_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count,
    output logic         wr_err,
    output logic         rd_err
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic         almost_full
`endif
);

    localparam int unsigned Depth = 2 ** AW;

    logic [W-1:0] mem [Depth];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] ram_q;
    logic         wr_acc;
    logic         rd_acc;

    // Extra pointer MSB separates the full and empty cases when the low bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count = wptr_q - rptr_q;

    always_comb begin
        wr_acc = wr_en & ~full;
        rd_acc = rd_en & ~empty;
        wptr_d = wptr_q + (AW + 1)'(wr_acc);
        rptr_d = rptr_q + (AW + 1)'(rd_acc);
    end

    // Storage is deliberately not reset; writes in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ram_q   <= '0;
            rd_data <= '0;
            wr_err  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (rd_acc) begin
                ram_q <= mem[rptr_q[AW-1:0]];
            end
            // Output register reloads from the RAM latch whenever enabled, even if empty.
            if (reg_en) begin
                rd_data <= ram_q;
            end
            wr_err <= wr_en & full;
            rd_err <= rd_en & empty;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [AW:0] count_d;

    assign count_d = wptr_d - rptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_d >= (AW + 1)'(AF_LVL));
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core (W=8, AW=4, AF_LVL=12) using a queue-based model.
// almost_full is checked when FIFO_ALMOST_FULL_EN is defined.
module tb_sync_fifo_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       reg_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       wr_err;
    logic       rd_err;
`ifdef FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    sync_fifo_core #(
        .W      (8),
        .AW     (4),
        .AF_LVL (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .reg_en      (reg_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .wr_err      (wr_err),
        .rd_err      (rd_err)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         r;
        bit         re;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         werr;
        bit         rerr;
        logic [7:0] rd;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] mq[$];
    logic [7:0] m_latch = 8'h00;
    logic [7:0] m_rd = 8'h00;
    bit         m_werr = 1'b0;
    bit         m_rerr = 1'b0;
    vec_t       tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_checks();
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("wr_err", 32'(wr_err), 32'(m_werr));
        chk("rd_err", 32'(rd_err), 32'(m_rerr));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
`ifdef FIFO_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
`endif
    endtask

    // One clock cycle of stimulus; the model is advanced with pre-edge state.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit re);
        bit         aw;
        bit         ar;
        logic [7:0] nrd;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        reg_en  = re;
        aw      = w && (mq.size() < 16);
        ar      = r && (mq.size() != 0);
        m_werr  = w && !aw;
        m_rerr  = r && !ar;
        nrd     = re ? m_latch : m_rd;
        if (ar) m_latch = mq.pop_front();
        if (aw) mq.push_back(d);
        m_rd = nrd;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        reg_en = 1'b0;
        model_checks();
    endtask

    // Requests are held active during reset to confirm they are ignored.
    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        rd_en   = 1'b1;
        reg_en  = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        reg_en = 1'b0;
        mq.delete();
        m_latch = 8'h00;
        m_rd    = 8'h00;
        m_werr  = 1'b0;
        m_rerr  = 1'b0;
        model_checks();
    endtask

    initial begin
        // w, d, r, re, count, empty, full, wr_err, rd_err, rd_data
        tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[2] = '{1'b1, 8'h6B, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
        tbl[5] = '{1'b1, 8'h7C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h6B};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7C};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7C};

        @(posedge clk);
        #1;
        do_reset();

        // Empty-read rejection, write-only when empty, and simultaneous read/write.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].re);
            chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].ful));
            chk($sformatf("tbl%0d.wr_err", i), 32'(wr_err), 32'(tbl[i].werr));
            chk($sformatf("tbl%0d.rd_err", i), 32'(rd_err), 32'(tbl[i].rerr));
            chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].rd));
        end

        // Fill to full, then overflow.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd16);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf.wr_err", 32'(wr_err), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf.wr_err_pulse", 32'(wr_err), 32'd0);

        // Drain; first pop also attempts a write while full (read only, write rejected).
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw.wr_err", 32'(wr_err), 32'd1);
        chk("full_rw.count", 32'(count), 32'd15);
        for (int i = 2; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            chk($sformatf("pop%0d.rd_data", i - 1), 32'(rd_data), 32'(i - 1));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pop16.rd_data", 32'(rd_data), 32'h10);
        chk("drain.empty", 32'(empty), 32'd1);

        // Steady state at count 8 with both pointers wrapping.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h28 + i), 1'b1, 1'b1);
        chk("stream.count", 32'(count), 32'd8);
        chk("stream.rd_data", 32'(rd_data), 32'h46);

        // Reset mid-operation at count 9.
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("pre_rst.count", 32'(count), 32'd9);
        do_reset();
        chk("mid_rst.empty", 32'(empty), 32'd1);
        chk("mid_rst.count", 32'(count), 32'd0);
        chk("mid_rst.rd_data", 32'(rd_data), 32'h00);

`ifdef FIFO_ALMOST_FULL_EN
        for (int i = 1; i <= 11; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("af.at11", 32'(almost_full), 32'd0);
        step(1'b1, 8'h0C, 1'b0, 1'b0);
        chk("af.at12", 32'(almost_full), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("af.read_to11", 32'(almost_full), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
SYNC_FIFO_CORE -- requirements
Module: sync_fifo_core

Interface
REQ-001 Parameter W, default 8, data width in bits.
REQ-002 Parameter AW, default 4, address width; depth is 2^AW entries.
REQ-003 Parameter AF_LVL, default 12, almost-full threshold in entries; used only when FIFO_ALMOST_FULL_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  W  write data.
REQ-008 rd_en  input  1  pop request; advances the RAM read stage.
REQ-009 reg_en  input  1  load enable for the output register.
REQ-010 rd_data  output  W  output-register data.
REQ-011 empty  output  1  no stored entries.
REQ-012 full  output  1  2^AW stored entries.
REQ-013 count  output  AW+1  stored entries, range 0..2^AW.
REQ-014 wr_err  output  1  one-cycle pulse on a rejected write.
REQ-015 rd_err  output  1  one-cycle pulse on a rejected read.
REQ-016 almost_full  output  1  count >= AF_LVL; port exists only with FIFO_ALMOST_FULL_EN.

Function
REQ-017 Storage SHALL be a 2^AW x W array with AW+1-bit write and read pointers; the extra MSB distinguishes full from empty.
REQ-018 empty SHALL be 1 when the pointers are equal, combinational from registered pointers.
REQ-019 full SHALL be 1 when the low AW pointer bits are equal and the MSBs differ, combinational from registered pointers.
REQ-020 count SHALL equal wptr minus rptr modulo 2^(AW+1).
REQ-021 Accepted write (wr_en & ~full): mem[wptr[AW-1:0]] <= wr_data; wptr increments.
REQ-022 Accepted read (rd_en & ~empty): RAM output latch <= mem[rptr[AW-1:0]]; rptr increments; latch is valid the next cycle.
REQ-023 reg_en SHALL load rd_data from the RAM output latch irrespective of empty; rd_data otherwise holds.
REQ-024 Latency: rd_en accepted in cycle N and reg_en in cycle N+1 SHALL present the word on rd_data in cycle N+2.
REQ-025 Write when full: no memory or pointer change; wr_err = 1 in the next cycle.
REQ-026 Read when empty: no pointer or latch change; rd_err = 1 in the next cycle.
REQ-027 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-028 When full, a simultaneous wr_en and rd_en SHALL perform the read only and reject the write (wr_err pulses).
REQ-029 When empty, a simultaneous wr_en and rd_en SHALL perform the write only and reject the read (rd_err pulses); there is no write-to-read bypass.
REQ-030 Pointers SHALL wrap naturally modulo 2^(AW+1); wrap-around SHALL NOT alter the data order.

Reset
REQ-031 With rst_n = 0 at a clock edge, wptr, rptr, the RAM latch, rd_data, wr_err and rd_err SHALL become 0.
REQ-032 After reset: empty = 1, full = 0, count = 0; almost_full = 0 when present.
REQ-033 The memory array SHALL NOT be reset.
REQ-034 Reset mid-operation SHALL discard all stored entries; requests in the reset cycle are ignored.

Configuration
REQ-035 When FIFO_ALMOST_FULL_EN is defined, almost_full SHALL exist as a port and be registered, asserting in the cycle after the edge where the updated count reaches AF_LVL or more.
REQ-036 When FIFO_ALMOST_FULL_EN is undefined, the almost_full port and its logic SHALL be absent; all other behaviour is identical.

Verification (W = 8, AW = 4, AF_LVL = 12)
REQ-037 Reset, then write 0x01..0x10 over 16 cycles -> full = 1, count = 16; a 17th write of 0xAA -> wr_err pulse, count stays 16.
REQ-038 From full, pop 16 words with reg_en one cycle after each rd_en -> rd_data = 0x01..0x10 in order, each 2 cycles after its rd_en; empty = 1 afterwards.
REQ-039 rd_en while empty -> rd_err pulse, rd_data unchanged; then wr_en and rd_en together while empty -> count = 1, rd_err pulses.
REQ-040 Hold count = 8, run 40 cycles of simultaneous read and write of an incrementing pattern -> count stays 8, both pointers wrap, output order is preserved.
REQ-041 With FIFO_ALMOST_FULL_EN defined: the 12th write -> almost_full = 1 in the following cycle; one read at count 12 -> almost_full = 0 in the following cycle.
REQ-042 Assert rst_n = 0 for one cycle at count 9 -> next cycle empty = 1, count = 0, rd_data = 0x00.
